// File: rtl/chip8_timer_ctrl.sv
// chip8_timer_ctrl
//   CHIP-8 delay timer (DT) and sound timer (ST), the shared 60 Hz prescaler
//   that decrements them, a req/ack access port for the CPU and the buzzer.
//
//   Handshake: the CPU raises req (with we/sel/wdata stable) and holds it
//   until it sees ack. The access is performed in the IDLE cycle where req is
//   seen. ack pulses for exactly one cycle, the cycle after acceptance. The
//   controller then waits for req to fall before it accepts again, so a held
//   req is never accepted twice.
//
// Ports
//   clk50     in   system clock
//   reset     in   asynchronous, active-high reset
//   req       in   access request, held until ack
//   we        in   1 = write, 0 = read
//   sel       in   0 = DT, 1 = ST
//   wdata     in   [7:0] write value
//   ack       out  one-cycle completion pulse
//   rdata     out  [7:0] read result, held until the next read completes
//   tick      out  one-cycle pulse at each 60 Hz boundary
//   dt_zero   out  DT == 0
//   sound_on  out  ST != 0
//   buzzer    out  square-wave tone, 0 whenever sound_on is 0
//   fsm_state out  [1:0] access FSM state (0 IDLE, 1 RESP, 2 WAIT)
module chip8_timer_ctrl #(
    parameter int TICK_DIV = 833333,
    parameter int TONE_DIV = 56818
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       req,
    input  logic       we,
    input  logic       sel,
    input  logic [7:0] wdata,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       tick,
    output logic       dt_zero,
    output logic       sound_on,
    output logic       buzzer,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int PW = $clog2(TICK_DIV);
    localparam int TW = $clog2(TONE_DIV);
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TONE_RELOAD  = TW'(TONE_DIV - 1);

    state_t        state;
    logic [PW-1:0] presc;
    logic [TW-1:0] tone;
    logic [7:0]    dt;
    logic [7:0]    st;
    logic [7:0]    dt_dec;
    logic [7:0]    st_dec;
    logic          buzz_q;
    logic          accept;

    assign tick      = (presc == '0);
    assign dt_zero   = (dt == 8'd0);
    assign sound_on  = (st != 8'd0);
    // Gated so that silencing ST takes the pin low in the same cycle.
    assign buzzer    = buzz_q & sound_on;
    assign fsm_state = state;
    assign accept    = (state == IDLE) && req;

    // Saturating next values after this cycle's tick (if any).
    assign dt_dec = (tick && dt != 8'd0) ? dt - 8'd1 : dt;
    assign st_dec = (tick && st != 8'd0) ? st - 8'd1 : st;

    // Free-running 60 Hz prescaler, independent of CPU accesses.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            presc <= PRESC_RELOAD;
        end else if (presc == '0) begin
            presc <= PRESC_RELOAD;
        end else begin
            presc <= presc - 1'b1;
        end
    end

    // A write to a timer overrides that timer's tick decrement.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            dt <= 8'd0;
            st <= 8'd0;
        end else begin
            dt <= (accept && we && !sel) ? wdata : dt_dec;
            st <= (accept && we &&  sel) ? wdata : st_dec;
        end
    end

    // Access FSM. Reads capture the post-tick value of the selected timer.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ack   <= 1'b0;
            rdata <= 8'd0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        ack   <= 1'b1;
                        state <= RESP;
                        if (!we) begin
                            rdata <= sel ? st_dec : dt_dec;
                        end
                    end
                end
                RESP: state <= WAIT;
                WAIT: if (!req) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tone generator: held at reload while silent so every burst begins
    // with a full low half-period.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            tone   <= TONE_RELOAD;
            buzz_q <= 1'b0;
        end else if (!sound_on) begin
            tone   <= TONE_RELOAD;
            buzz_q <= 1'b0;
        end else if (tone == '0) begin
            tone   <= TONE_RELOAD;
            buzz_q <= ~buzz_q;
        end else begin
            tone <= tone - 1'b1;
        end
    end

endmodule

// File: tb/tb_chip8_timer_ctrl.sv
// Testbench for chip8_timer_ctrl with TICK_DIV=10, TONE_DIV=3.
// The reference model describes each timer by its last write (cycle, value)
// and derives the current value from the number of ticks since then; ticks
// fall on cycles where cycle % TICK_DIV == TICK_DIV-1 (cycle 0 = first cycle
// after reset release).
module tb_chip8_timer_ctrl;
  localparam int TD = 10;
  localparam int TN = 3;

  logic       clk;
  logic       reset;
  logic       req;
  logic       we;
  logic       sel;
  logic [7:0] wdata;
  logic       ack;
  logic [7:0] rdata;
  logic       tick;
  logic       dt_zero;
  logic       sound_on;
  logic       buzzer;
  logic [1:0] fsm_state;

  chip8_timer_ctrl #(.TICK_DIV(TD), .TONE_DIV(TN)) dut (
    .clk50    (clk),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .sel      (sel),
    .wdata    (wdata),
    .ack      (ack),
    .rdata    (rdata),
    .tick     (tick),
    .dt_zero  (dt_zero),
    .sound_on (sound_on),
    .buzzer   (buzzer),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [40:0] exp_q[$];   // {ack cycle[31:0], is_read, data[7:0]}

  int wc_cur[2];
  int v_cur[2];
  int wc_prev[2];
  int v_prev[2];
  int rd_model;
  int snd_start;
  bit prev_on;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int ticks_upto(input int x);
    return (x + 1) / TD;
  endfunction

  // Timer value as seen during cycle t.
  function automatic int val_at(input int s, input int t);
    int wc;
    int v;
    int decs;
    if (wc_cur[s] < t) begin wc = wc_cur[s]; v = v_cur[s]; end
    else begin wc = wc_prev[s]; v = v_prev[s]; end
    decs = ticks_upto(t - 1) - ticks_upto(wc);
    return (v > decs) ? v - decs : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      wc_cur[i] = -1; v_cur[i] = 0; wc_prev[i] = -1; v_prev[i] = 0;
    end
    exp_q.delete();
  endtask

  // ---------------- monitor ----------------
  int t;
  int dtv;
  int stv;
  int exp_buz;
  logic [40:0] e;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_ack", int'(ack), 0);
      check("rst_rdata", int'(rdata), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_dt_zero", int'(dt_zero), 1);
      check("rst_sound_on", int'(sound_on), 0);
      check("rst_buzzer", int'(buzzer), 0);
      check("rst_fsm", int'(fsm_state), 0);
      rd_model = 0;
      prev_on = 1'b0;
    end else begin
      t = cyc;
      dtv = val_at(0, t);
      stv = val_at(1, t);
      check("tick", int'(tick), ((t % TD) == TD - 1) ? 1 : 0);
      check("dt_zero", int'(dt_zero), (dtv == 0) ? 1 : 0);
      check("sound_on", int'(sound_on), (stv != 0) ? 1 : 0);
      if (stv != 0) begin
        if (!prev_on) snd_start = t;
        exp_buz = ((t - snd_start) / TN) % 2;
      end else begin
        exp_buz = 0;
      end
      prev_on = (stv != 0);
      check("buzzer", int'(buzzer), exp_buz);
      if (ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("ack_cycle", t, int'(e[40:9]));
          if (e[8]) rd_model = int'(e[7:0]);
        end
      end else if (exp_q.size() != 0 && int'(exp_q[0][40:9]) < t) begin
        e = exp_q.pop_front();
        check("missing_ack", t, int'(e[40:9]));
      end
      check("rdata", int'(rdata), rd_model);
    end
  end

  // ---------------- driver tasks (called just after a negedge) ----------------
  task automatic do_access(input logic w, input logic s, input logic [7:0] d, input int hold);
    int n;
    bit got;
    n = cyc;
    req = 1'b1; we = w; sel = s; wdata = d;
    if (w) begin
      wc_prev[s] = wc_cur[s]; v_prev[s] = v_cur[s];
      wc_cur[s] = n; v_cur[s] = int'(d);
      exp_q.push_back({32'(n + 1), 1'b0, d});
    end else begin
      exp_q.push_back({32'(n + 1), 1'b1, 8'(val_at(s, n + 1))});
    end
    got = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack) begin got = 1'b1; break; end
    end
    check("ack_seen", int'(got), 1);
    repeat (hold) @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick_cycle();
    for (int i = 0; i < TD + 1; i++) begin
      if ((cyc % TD) == TD - 1) break;
      @(negedge clk);
    end
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    model_reset();
    repeat (cycles) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; sel = 1'b0; wdata = 8'd0;
    model_reset();
    rd_model = 0;
    prev_on = 1'b0;
    snd_start = 0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);

    // Idle: ticks at 9, 19, 29, no sound.
    idle(32);

    // DT = 3, read after three ticks.
    do_access(1'b1, 1'b0, 8'd3, 0);
    idle(30);
    do_access(1'b0, 1'b0, 8'd0, 0);

    // ST = 2: tone for two ticks.
    do_access(1'b1, 1'b1, 8'd2, 0);
    idle(25);

    // Write beats tick.
    do_access(1'b1, 1'b1, 8'd7, 0);
    wait_tick_cycle();
    do_access(1'b1, 1'b0, 8'd5, 0);
    do_access(1'b0, 1'b0, 8'd0, 0);
    do_access(1'b0, 1'b1, 8'd0, 0);

    // Held req: one ack only.
    do_access(1'b0, 1'b0, 8'd0, 10);
    do_access(1'b0, 1'b1, 8'd0, 0);

    // Silencing ST.
    do_access(1'b1, 1'b1, 8'd9, 0);
    idle(7);
    do_access(1'b1, 1'b1, 8'd0, 0);
    idle(4);

    // Randomized accesses, some aligned with ticks.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) wait_tick_cycle();
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 12)), $urandom_range(0, 3));
      idle($urandom_range(0, 12));
    end

    // Reset during RESP of a read after DT = 9.
    do_access(1'b1, 1'b0, 8'd9, 0);
    do_access(1'b1, 1'b1, 8'd4, 0);
    req = 1'b1; we = 1'b0; sel = 1'b0;
    exp_q.push_back({32'(cyc + 1), 1'b1, 8'(val_at(0, cyc + 1))});
    @(posedge clk);
    #1;
    req = 1'b0;
    apply_reset(2);
    idle(25);
    do_access(1'b0, 1'b0, 8'd0, 0);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
